stream_demux: RTL and testbench



---
 rtl/stream_demux_pkg.sv | 8 +
 rtl/stream_demux_if.sv | 27 ++
 rtl/stream_demux_slice.sv | 40 ++++
 rtl/stream_demux.sv | 118 +++++++++++
 tb/tb_stream_demux.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux block.
package stream_demux_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, PASS, DROP} demux_state_t;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle between one producer, the demux and its N_OUT consumers.
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
);
  localparam int SEL_W = $clog2(N_OUT);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [SEL_W-1:0] in_sel;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_demux_slice.sv
// One-entry registered output buffer; dest_ready is the ready of the buffered destination.
module stream_demux_slice #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic [SEL_W-1:0] load_dest,
  input  logic             dest_ready,
  output logic             in_ready,
  output logic             buf_valid,
  output logic [WIDTH-1:0] buf_data,
  output logic             buf_last,
  output logic [SEL_W-1:0] buf_dest
);

  assign in_ready = !buf_valid || dest_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the payload register is reset too, so out_data reads 0 rather than X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      buf_last  <= 1'b0;
      buf_dest  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_data  <= load_data;
      buf_last  <= load_last;
      buf_dest  <= load_dest;
    end else if (buf_valid && dest_ready) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N_OUT packet demux: select locked on the first beat, out-of-range packets dropped.
// Define STREAM_DEMUX_CNT_EN to add per-channel beat counters and a drop counter.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stream_demux_if.slave          bus
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0] cnt,
  output logic [CNT_W-1:0]       drop_cnt
`endif
);

  localparam int SEL_W = $clog2(N_OUT);
  localparam logic [SEL_W:0] N_OUT_L = N_OUT[SEL_W:0];

  demux_state_t     state, state_nxt;
  logic [SEL_W-1:0] locked_dest, locked_nxt, dest;
  logic             in_ready, accept, load, in_range, dest_ready;
  logic             buf_valid, buf_last;
  logic [WIDTH-1:0] buf_data;
  logic [SEL_W-1:0] buf_dest;
  logic [N_OUT-1:0] out_valid;

  assign accept     = bus.in_valid && in_ready;
  assign in_range   = {1'b0, bus.in_sel} < N_OUT_L;
  assign dest_ready = bus.out_ready[buf_dest];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      locked_dest <= '0;
    end else begin
      state       <= state_nxt;
      locked_dest <= locked_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    locked_nxt = locked_dest;
    dest       = bus.in_sel;
    load       = 1'b0;
    case (state)
      IDLE: begin
        load = accept && in_range;
        if (accept && !bus.in_last) begin
          state_nxt  = in_range ? PASS : DROP;
          locked_nxt = bus.in_sel;
        end
      end
      PASS: begin
        dest = locked_dest;
        load = accept;
        if (accept && bus.in_last) state_nxt = IDLE;
      end
      DROP: begin
        if (accept && bus.in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  stream_demux_slice #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (bus.in_data),
    .load_last  (bus.in_last),
    .load_dest  (dest),
    .dest_ready (dest_ready),
    .in_ready   (in_ready),
    .buf_valid  (buf_valid),
    .buf_data   (buf_data),
    .buf_last   (buf_last),
    .buf_dest   (buf_dest)
  );

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < N_OUT; i++) out_valid[i] = buf_valid && (buf_dest == SEL_W'(i));
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = buf_data;
  assign bus.out_last  = buf_last;

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_OUT];
  logic [CNT_W-1:0] drop_q;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (out_valid[i] && bus.out_ready[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      if (accept && !load && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: packet-level scoreboard on a 4-channel instance plus a 3-channel drop case.
module tb_stream_demux;
  import stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8), .N_OUT(4)) if4 ();
  stream_demux_if #(.WIDTH(8), .N_OUT(3)) if3 ();

`ifdef STREAM_DEMUX_CNT_EN
  logic [4*CNT_W-1:0] cnt4;
  logic [CNT_W-1:0]   drop4;
  logic [3*CNT_W-1:0] cnt3;
  logic [CNT_W-1:0]   drop3;
`endif

  stream_demux #(.WIDTH(8), .N_OUT(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if4)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt      (cnt4),
    .drop_cnt (drop4)
`endif
  );

  stream_demux #(.WIDTH(8), .N_OUT(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if3)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt      (cnt3),
    .drop_cnt (drop3)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of routed beats awaiting delivery plus the open-packet routing decision.
  typedef struct {
    int         dest;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      q[$];
  logic [7:0] m_data;
  logic       m_last;
  bit         pkt_open;
  int         pkt_dest;
  bit         pkt_drop;
  int         exp_cnt[4];
  int         exp_drop;

  task automatic model_reset();
    q.delete();
    m_data   = 8'h00;
    m_last   = 1'b0;
    pkt_open = 1'b0;
    pkt_dest = 0;
    pkt_drop = 1'b0;
    for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
    exp_drop = 0;
  endtask

  task automatic drive4(input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic l, input logic [3:0] r);
    if4.in_valid  = v;
    if4.in_sel    = s;
    if4.in_data   = d;
    if4.in_last   = l;
    if4.out_ready = r;
  endtask

  task automatic drive3(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    if3.in_valid = v;
    if3.in_sel   = s;
    if3.in_data  = d;
    if3.in_last  = l;
  endtask

  // Called at a falling edge with inputs already driven: compare, clock, then advance the model.
  task automatic cycle();
    bit         er, acc, fire, drop;
    logic [3:0] ev;
    int         d;
    beat_t      b;
    #1;
    fire = (q.size() != 0) && if4.out_ready[q[0].dest];
    er   = (q.size() == 0) || if4.out_ready[q[0].dest];
    ev   = (q.size() != 0) ? 4'(1 << q[0].dest) : 4'b0000;
    acc  = if4.in_valid && er;
    check("in_ready", if4.in_ready, er);
    check("out_valid", if4.out_valid, ev);
    check("out_data", if4.out_data, m_data);
    check("out_last", if4.out_last, m_last);
`ifdef STREAM_DEMUX_CNT_EN
    for (int c = 0; c < 4; c++) check("cnt", cnt4[c*CNT_W +: CNT_W], exp_cnt[c]);
    check("drop_cnt", drop4, exp_drop);
`endif
    @(posedge clk);
    if (fire) begin
      if (exp_cnt[q[0].dest] < 65535) exp_cnt[q[0].dest]++;
      void'(q.pop_front());
    end
    if (acc) begin
      if (!pkt_open) begin
        d    = int'(if4.in_sel);
        drop = (d >= 4);
      end else begin
        d    = pkt_dest;
        drop = pkt_drop;
      end
      if (drop) begin
        if (exp_drop < 65535) exp_drop++;
      end else begin
        b.dest = d;
        b.data = if4.in_data;
        b.last = if4.in_last;
        q.push_back(b);
        m_data = if4.in_data;
        m_last = if4.in_last;
      end
      pkt_open = !if4.in_last;
      pkt_dest = d;
      pkt_drop = drop;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    drive4(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    drive3(1'b0, 2'd0, 8'h00, 1'b0);
    if3.out_ready = 3'b111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state on both instances.
    #1;
    check("rst3_in_ready", if3.in_ready, 1'b1);
    check("rst3_out_valid", if3.out_valid, 3'b000);
    check("rst3_out_data", if3.out_data, 8'h00);
    cycle();

    // Single beat to channel 2.
    drive4(1'b1, 2'd2, 8'hA5, 1'b1, 4'hF);
    cycle();
    check("t1_valid", if4.out_valid, 4'b0100);
    check("t1_data", if4.out_data, 8'hA5);
    check("t1_last", if4.out_last, 1'b1);
    check("t1_ready", if4.in_ready, 1'b1);

    // Three-beat packet: select locked to 1 despite later in_sel=3.
    drive4(1'b1, 2'd1, 8'h11, 1'b0, 4'hF);
    cycle();
    check("t2_b0", {if4.out_valid, if4.out_data, if4.out_last}, {4'b0010, 8'h11, 1'b0});
    drive4(1'b1, 2'd3, 8'h22, 1'b0, 4'hF);
    cycle();
    check("t2_b1", {if4.out_valid, if4.out_data, if4.out_last}, {4'b0010, 8'h22, 1'b0});
    drive4(1'b1, 2'd3, 8'h33, 1'b1, 4'hF);
    cycle();
    check("t2_b2", {if4.out_valid, if4.out_data, if4.out_last}, {4'b0010, 8'h33, 1'b1});

    // Backpressure on channel 0 stalls the input even though channel 1 is ready.
    drive4(1'b1, 2'd0, 8'h44, 1'b1, 4'b1110);
    cycle();
    drive4(1'b1, 2'd1, 8'h55, 1'b1, 4'b1110);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t3_stall", if4.in_ready, 1'b0);
      check("t3_hold", {if4.out_valid, if4.out_data}, {4'b0001, 8'h44});
    end
    if4.out_ready = 4'hF;
    cycle();
    check("t3_release", {if4.out_valid, if4.out_data}, {4'b0010, 8'h55});

    // Back-to-back single-beat packets alternating between channels 0 and 1.
    for (int k = 0; k < 8; k++) begin
      drive4(1'b1, 2'(k % 2), 8'(8'h60 + k), 1'b1, 4'hF);
      cycle();
      check("t6_valid", if4.out_valid, (k % 2) ? 4'b0010 : 4'b0001);
      check("t6_data", if4.out_data, 8'(8'h60 + k));
    end

    // Asynchronous reset in the middle of a packet.
    drive4(1'b1, 2'd1, 8'h77, 1'b0, 4'b0000);
    cycle();
    drive4(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", if4.out_valid, 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive4(1'b1, 2'd2, 8'h88, 1'b0, 4'hF);
    cycle();
    check("t5_route", {if4.out_valid, if4.out_data}, {4'b0100, 8'h88});
    drive4(1'b1, 2'd0, 8'h89, 1'b1, 4'hF);
    cycle();
    check("t5_locked", if4.out_valid, 4'b0100);
    drive4(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    cycle();

    // Out-of-range packet on the 3-channel instance is swallowed whole.
    drive3(1'b1, 2'd3, 8'hD0, 1'b0);
    #1;
    check("t4_ready0", if3.in_ready, 1'b1);
    cycle();
    check("t4_drop0", if3.out_valid, 3'b000);
    drive3(1'b1, 2'd0, 8'hD1, 1'b1);
    #1;
    check("t4_ready1", if3.in_ready, 1'b1);
    cycle();
    check("t4_drop1", if3.out_valid, 3'b000);
    drive3(1'b1, 2'd0, 8'h5A, 1'b1);
    cycle();
    check("t4_route", {if3.out_valid, if3.out_data, if3.out_last}, {3'b001, 8'h5A, 1'b1});
`ifdef STREAM_DEMUX_CNT_EN
    check("t4_drop_cnt", drop3, 16'd2);
`endif
    drive3(1'b0, 2'd0, 8'h00, 1'b0);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 400; k++) begin
      drive4(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
             ($urandom_range(0, 2) == 0), 4'($urandom));
      cycle();
    end

    drive4(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    repeat (3) cycle();
    check("final_drained", if4.out_valid, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
